// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, services it after a
// fixed latency, and returns lane-selected, extended load data on a response channel.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // The operation being executed: live request inputs while idle (only used when
    // LATENCY is 1 and the access happens on the accept edge), latched copy otherwise.
    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_size;
    logic        op_write;

    logic [31:0] off;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        op_err;
    logic [3:0]  be;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic        mem_we;
    logic        accept;

    assign op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign op_size  = (state_q == S_IDLE) ? req_size  : size_q;
    assign op_write = (state_q == S_IDLE) ? req_write : write_q;

    assign req_ready  = (state_q == S_IDLE) && rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    // Address decode, error classification, store lane enables and load extension.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        off      = op_addr - BASE_ADDR;
        lane     = off[1:0];
        idx      = off[AW+1:2];
        rd_word  = mem_q[idx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
        op_err   = (op_addr < BASE_ADDR) || (off >= SPAN);
        be       = 4'b0000;
        wr_word  = '0;
        ld_data  = '0;
        case (op_size)
            SZ_B: begin
                be      = 4'b0001 << lane;
                wr_word = {4{op_wdata[7:0]}};
                ld_data = {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_BU: begin
                op_err  = op_err || op_write;
                ld_data = {24'h0, byte_sel};
            end
            SZ_H: begin
                op_err  = op_err || op_addr[0];
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{op_wdata[15:0]}};
                ld_data = {{16{half_sel[15]}}, half_sel};
            end
            SZ_HU: begin
                op_err  = op_err || op_addr[0] || op_write;
                ld_data = {16'h0, half_sel};
            end
            SZ_W: begin
                op_err  = op_err || (op_addr[1:0] != 2'b00);
                be      = 4'b1111;
                wr_word = op_wdata;
                ld_data = rd_word;
            end
            default: op_err = 1'b1;
        endcase
    end

    // Next-state logic: accept, count down, then commit/read and hold the response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    write_d = req_write;
                    if (LATENCY == 1) begin
                        mem_we  = op_write && !op_err;
                        err_d   = op_err;
                        rdata_d = (op_err || op_write) ? 32'h0 : ld_data;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // The counter reaching zero on this edge is the commit point.
                if (cnt_q == 4'd1) begin
                    mem_we  = op_write && !op_err;
                    err_d   = op_err;
                    rdata_d = (op_err || op_write) ? 32'h0 : ld_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array with per-byte write enables.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive reset and map onto RAM.
        for (int i = 0; i < 4; i++) begin
            if (mem_we && be[i]) mem_q[idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) checked against a
// byte-addressed reference memory with directed and randomized transactions.
module tb_data_mem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          NB    = 4 * DEPTH;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_size   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    logic [7:0] bmem [2][NB];

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, rules applied directly.
    function automatic void model(input int d, input logic w, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] off;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        case (sz)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        if (n == 0) er = 1'b1;
        if (w && sz[2]) er = 1'b1;
        if (n > 1 && (a % n) != 0) er = 1'b1;
        if (a < BASE || (a - BASE) >= 32'(NB)) er = 1'b1;
        if (er) return;
        off = a - BASE;
        if (w) begin
            for (int i = 0; i < n; i++) bmem[d][off + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(bmem[d][off + i]) << (8 * i));
            if (!sz[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    // One full transaction on instance d, with timing, hold-stability and result checks.
    task automatic txn(input int d, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold, input bit early,
                       output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd, r0;
        logic        exp_er, e0;
        int          n, lat;
        bit          ready_ok, stable_ok;
        lat = (d == 0) ? 2 : 1;
        model(d, w, sz, a, wd, exp_rd, exp_er);
        req_write[d] = w;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        step();
        req_valid[d] = 1'b0;
        if (early) resp_ready[d] = 1'b1;
        n = 1;
        ready_ok = 1'b1;
        while (resp_valid[d] !== 1'b1 && n < 20) begin
            if (req_ready[d] !== 1'b0) ready_ok = 1'b0;
            step();
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        rd = 32'hx;
        er = 1'bx;
        if (n >= 20) begin
            resp_ready[d] = 1'b0;
            return;
        end
        if (req_ready[d] !== 1'b0) ready_ok = 1'b0;
        r0 = resp_rdata[d];
        e0 = resp_err[d];
        stable_ok = 1'b1;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                step();
                if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== r0 ||
                    resp_err[d] !== e0 || req_ready[d] !== 1'b0) stable_ok = 1'b0;
            end
        end
        check("busy_ready_low", 32'(ready_ok), 32'd1);
        check("hold_stable", 32'(stable_ok), 32'd1);
        check("rdata", r0, exp_rd);
        check("err", 32'(e0), 32'(exp_er));
        resp_ready[d] = 1'b1;
        step();
        resp_ready[d] = 1'b0;
        check("post_hs_valid", 32'(resp_valid[d]), 32'd0);
        check("post_hs_ready", 32'(req_ready[d]), 32'd1);
        rd = r0;
        er = e0;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er;
        logic [2:0]  sz;
        int          d, r;

        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;   req_size[k]  = '0;   resp_ready[k] = 1'b0;
        end
        step();
        step();
        rst = 1'b1;
        step();
        check("reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("reset_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("reset_rdata", resp_rdata[0], 32'h0);
        check("reset_err", 32'(resp_err[0]), 32'd0);

        // Give every word a defined value in both instances.
        for (int k = 0; k < 2; k++)
            for (int wi = 0; wi < DEPTH; wi++)
                txn(k, 1'b1, 3'b010, BASE + 32'(4 * wi), $urandom, 0, 1'b0, rd, er);

        // Word store/load.
        txn(0, 1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF, 0, 1'b0, rd, er);
        txn(0, 1'b0, 3'b010, 32'h0001_0000, 32'h0, 0, 1'b0, rd, er);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);

        // Byte lane store and extension.
        txn(0, 1'b1, 3'b010, 32'h0001_0000, 32'h1122_3344, 0, 1'b0, rd, er);
        txn(0, 1'b1, 3'b000, 32'h0001_0001, 32'h0000_00AA, 0, 1'b0, rd, er);
        txn(0, 1'b0, 3'b010, 32'h0001_0000, 32'h0, 0, 1'b0, rd, er);
        check("sb_merge", rd, 32'h1122_AA44);
        txn(0, 1'b0, 3'b000, 32'h0001_0001, 32'h0, 0, 1'b0, rd, er);
        check("lb_sign", rd, 32'hFFFF_FFAA);
        txn(0, 1'b0, 3'b100, 32'h0001_0001, 32'h0, 0, 1'b0, rd, er);
        check("lbu_zero", rd, 32'h0000_00AA);

        // Halfword store, extension, misaligned load.
        txn(0, 1'b1, 3'b001, 32'h0001_0006, 32'h0000_8001, 0, 1'b0, rd, er);
        txn(0, 1'b0, 3'b001, 32'h0001_0006, 32'h0, 0, 1'b0, rd, er);
        check("lh_sign", rd, 32'hFFFF_8001);
        txn(0, 1'b0, 3'b101, 32'h0001_0006, 32'h0, 0, 1'b0, rd, er);
        check("lhu_zero", rd, 32'h0000_8001);
        txn(0, 1'b0, 3'b001, 32'h0001_0005, 32'h0, 0, 1'b0, rd, er);
        check("lh_misaligned_err", 32'(er), 32'd1);
        txn(0, 1'b0, 3'b010, 32'h0001_0004, 32'h0, 0, 1'b0, rd, er);

        // Error cases; the model confirms nothing is written afterwards.
        txn(0, 1'b0, 3'b010, 32'h0000_FFFC, 32'h0, 0, 1'b0, rd, er);
        check("below_base_err", 32'(er), 32'd1);
        txn(0, 1'b0, 3'b010, BASE + 32'(NB), 32'h0, 0, 1'b0, rd, er);
        check("above_top_err", 32'(er), 32'd1);
        txn(0, 1'b1, 3'b010, 32'h0001_0002, 32'hCAFE_F00D, 0, 1'b0, rd, er);
        check("sw_misaligned_err", 32'(er), 32'd1);
        txn(0, 1'b0, 3'b011, 32'h0001_0000, 32'h0, 0, 1'b0, rd, er);
        check("size011_err", 32'(er), 32'd1);
        txn(0, 1'b1, 3'b101, 32'h0001_0000, 32'hFFFF_FFFF, 0, 1'b0, rd, er);
        txn(0, 1'b0, 3'b010, 32'h0001_0000, 32'h0, 0, 1'b0, rd, er);
        check("no_write_after_err", rd, 32'h1122_AA44);
        txn(0, 1'b0, 3'b010, BASE + 32'(NB) - 4, 32'h0, 0, 1'b0, rd, er);
        check("last_word_ok", 32'(er), 32'd0);

        // Backpressure: response held for five cycles.
        txn(0, 1'b0, 3'b001, 32'h0001_0006, 32'h0, 5, 1'b0, rd, er);
        check("backpressure_data", rd, 32'hFFFF_8001);

        // Reset while a store is waiting: store is dropped.
        req_write[0] = 1'b1; req_size[0] = 3'b010;
        req_addr[0] = 32'h0001_0008; req_wdata[0] = 32'h1234_5678;
        req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(resp_valid[0]), 32'd0);
        check("midrst_rdata", resp_rdata[0], 32'h0);
        check("midrst_err", 32'(resp_err[0]), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_ready", 32'(req_ready[0]), 32'd1);
        txn(0, 1'b0, 3'b010, 32'h0001_0008, 32'h0, 0, 1'b0, rd, er);

        // LATENCY=1 instance.
        txn(1, 1'b1, 3'b010, 32'h0001_0010, 32'hA5A5_5A5A, 0, 1'b0, rd, er);
        txn(1, 1'b0, 3'b001, 32'h0001_0012, 32'h0, 2, 1'b0, rd, er);
        check("lat1_lh", rd, 32'hFFFF_A5A5);

        // Randomized traffic on both instances.
        for (int t = 0; t < 300; t++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 1) a = BASE + 32'(NB) + 32'($urandom_range(0, 15));
            else             a = BASE + 32'($urandom_range(0, NB - 1));
            if (r > 1 && $urandom_range(0, 1) == 1) a = a & ~32'h3;
            sz = 3'($urandom_range(0, 7));
            txn(d, 1'($urandom_range(0, 1)), sz, a, $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the pipeline's data-memory interface.
- The memory stage is the initiator: it issues load/store requests over a valid/ready handshake.
- This block services each request with a fixed multi-cycle latency, performs byte/half/word lane selection, sign/zero-extends load data, and returns a response on a second valid/ready channel.
- It replaces the single-cycle data array for multi-cycle memory bring-up.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the storage array.
- BASE_ADDR, 32'h0001_0000, byte address of word 0.
- LATENCY, 2, cycles from request-accept edge to resp_valid rising; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  output  1  request was rejected (misaligned, out of range, or illegal size).

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Outputs: req_ready=1 once rst deasserts, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - The storage array is not cleared.
  - Reset mid-transaction drops any pending request and response; an uncommitted store is never written.
- FSM states:
  - IDLE:
    - req_ready=1.
    - On req_valid&&req_ready: latch addr, wdata, size, write; load counter with LATENCY-1; go to WAIT, or straight to RESP when LATENCY=1.
  - WAIT:
    - req_ready=0; counter decrements each cycle.
    - When the counter reaches 0: go to RESP, and commit the store or read the array on that same edge.
  - RESP:
    - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
    - On the handshake edge: resp_valid drops and state returns to IDLE, so req_ready=1 in the next cycle.
    - No back-to-back overlap: at most one outstanding request.
- Latency:
  - resp_valid rises exactly LATENCY cycles after the accept edge.
  - The store commits at that same edge.
  - A load issued after a store's response handshake returns the new data.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - Out of range when req_addr < BASE_ADDR or off >= DEPTH_WORDS*4.
  - Word index = off[..:2]; byte lane = off[1:0]; little-endian.
- Error conditions (resp_err=1, no array write, resp_rdata=0):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Address out of range.
  - req_size of 011, 110 or 111.
  - req_write=1 with size 100 or 101.
- Stores, byte-lane writes only:
  - B writes lane off[1:0] with wdata[7:0].
  - H writes lanes {off[1],0} and {off[1],1} with wdata[15:0].
  - W writes all four lanes.
  - Other bytes are untouched.
- Loads:
  - B/H are sign-extended from bit 7/15 of the selected lane(s).
  - BU/HU are zero-extended.
  - W returns the full word.
- Simultaneous events:
  - A req_valid in WAIT/RESP is ignored (req_ready=0); the initiator must hold it.
  - resp_ready asserted before resp_valid has no effect.

Test Plan:
- Reset then LW with the array preloaded: word@0x10000=0xDEADBEEF; req at cycle 0 -> resp_valid at cycle 2, rdata=0xDEADBEEF, err=0; req_ready=0 in cycles 1-2, and 1 in the cycle after the handshake.
- Byte store: SB wdata=0x000000AA addr 0x10001 onto word 0x11223344 -> later LW returns 0x1122AA44; LB addr 0x10001 -> 0xFFFFFFAA; LBU -> 0x000000AA.
- Halfword: SH 0x8001 at 0x10006 -> LH 0x10006 = 0xFFFF8001, LHU = 0x00008001; LH at 0x10005 -> err=1, rdata=0, array unchanged.
- Errors: LW at 0x0000FFFC, LW at 0x10000+4*DEPTH_WORDS, SW at 0x10002, and req_size=011 -> each err=1, no write, response still arrives at latency 2.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable, req_ready=0 throughout; handshake on cycle 6 -> IDLE next cycle.
- Reset mid-operation: accept SW 0x12345678 @0x10008, pull rst low in the WAIT cycle -> outputs at reset values immediately; subsequent LW @0x10008 returns the old value; with LATENCY=1 the response arrives one cycle after accept.
